// File: rtl/fetch_unit_pkg.sv
// rv_fetch_pkg: shared widths, fetch-buffer entry type, fetch FSM states and alignment helper.
package rv_fetch_pkg;
  localparam int XLEN = 32;
  localparam int ILEN = 32;
  localparam int INSTR_BYTES = 4;
  typedef struct packed {
    logic [ILEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;
  typedef enum logic {FETCH, FAULT} pc_state_e;
  function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
    return (addr & XLEN'(INSTR_BYTES - 1)) != '0;
  endfunction
endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory, decode handshake, redirect and fault signals of the fetch stage.
interface fetch_unit_if;
  import rv_fetch_pkg::*;
  logic [XLEN-1:0] imem_addr;
  logic [ILEN-1:0] imem_rdata;
  logic            if_valid;
  logic            if_ready;
  logic [ILEN-1:0] if_instr;
  logic [XLEN-1:0] if_pc;
  logic [XLEN-1:0] if_pc_plus4;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            fetch_fault;
  logic [XLEN-1:0] fault_pc;
  modport master (
    output imem_addr, if_valid, if_instr, if_pc, if_pc_plus4, fetch_fault, fault_pc,
    input  imem_rdata, if_ready, redirect_valid, redirect_pc
  );
  modport slave (
    input  imem_addr, if_valid, if_instr, if_pc, if_pc_plus4, fetch_fault, fault_pc,
    output imem_rdata, if_ready, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/fetch_unit_fifo.sv
// fetch_fifo: small synchronous FIFO of fetch entries with flush; head reads as zero while empty.
module fetch_fifo
  import rv_fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic                       i_flush,
  input  fetch_entry_t               i_data,
  output logic                       o_full,
  output logic                       o_empty,
  output fetch_entry_t               o_head,
  output logic [$clog2(DEPTH):0]     o_count
);
  localparam int AW = $clog2(DEPTH);
  fetch_entry_t r_mem [DEPTH];
  logic [AW-1:0] r_head, r_tail;
  logic [AW:0]   r_count;
  logic          w_push, w_pop;
  assign o_full  = r_count == (AW+1)'(DEPTH);
  assign o_empty = r_count == '0;
  assign w_pop   = i_pop & !o_empty & !i_flush;
  assign w_push  = i_push & (!o_full | w_pop) & !i_flush;
  assign o_head  = o_empty ? '0 : r_mem[r_head];
  assign o_count = r_count;
  always_ff @(posedge clk or posedge rst) begin
    if (rst || i_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + 1'b1;
      if (w_pop) r_head <= r_head + 1'b1;
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end
  always_ff @(posedge clk)
    if (w_push) r_mem[r_tail] <= i_data;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC, fetches from instruction memory into a small buffer and hands
// {instr, pc, pc+4} to decode; execute redirects flush and reload, bad addresses latch a fault.
module fetch_unit
  import rv_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
  parameter int              FIFO_DEPTH = 2,
  parameter int              IMEM_WORDS = 1024
) (
  input logic           clk,
  input logic           rst,
  fetch_unit_if.master  bus
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [XLEN:0] PC_LIMIT = (XLEN+1)'(IMEM_WORDS) * (XLEN+1)'(INSTR_BYTES);
  pc_state_e       r_state, w_state_nxt;
  logic [XLEN-1:0] r_pc, w_pc_nxt, r_fault_pc, w_fault_pc_nxt;
  logic            w_faulted, w_in_range, w_flush, w_push, w_pop, w_full, w_empty;
  logic [CW-1:0]   w_count;
  fetch_entry_t    w_head;
  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_fault_pc_nxt = r_fault_pc;
    w_faulted      = r_state == FAULT;
    w_in_range     = {1'b0, r_pc} < PC_LIMIT;
    w_flush        = bus.redirect_valid & !w_faulted;
    w_pop          = bus.if_valid & bus.if_ready;
    w_push         = !w_faulted & !bus.redirect_valid & (!w_full | w_pop) & w_in_range;
    // Redirect outranks the range check: the PC about to be replaced never faults.
    if (w_flush) begin
      w_state_nxt    = is_misaligned(bus.redirect_pc) ? FAULT : FETCH;
      w_fault_pc_nxt = is_misaligned(bus.redirect_pc) ? bus.redirect_pc : r_fault_pc;
      w_pc_nxt       = is_misaligned(bus.redirect_pc) ? r_pc : bus.redirect_pc;
    end else if (!w_faulted && !w_in_range) begin
      w_state_nxt    = FAULT;
      w_fault_pc_nxt = r_pc;
    end else if (w_push) begin
      w_pc_nxt = r_pc + XLEN'(INSTR_BYTES);
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= FETCH;
      r_pc       <= RESET_PC;
      r_fault_pc <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_fault_pc <= w_fault_pc_nxt;
    end
  end
  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .i_data  ({bus.imem_rdata, r_pc}),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head),
    .o_count (w_count)
  );
  assign bus.imem_addr   = r_pc;
  assign bus.if_valid    = w_count != '0;
  assign bus.if_instr    = w_head.instr;
  assign bus.if_pc       = w_head.pc;
  assign bus.if_pc_plus4 = w_empty ? '0 : w_head.pc + XLEN'(INSTR_BYTES);
  assign bus.fetch_fault = r_state == FAULT;
  assign bus.fault_pc    = r_fault_pc;
endmodule
